// File: rtl/ex_stage.sv
// Execute stage: combinational ALU with a single registered output slot and
// valid/ready handshake (one op per cycle when downstream keeps up).
module ex_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_alu_ctrl,
    input  logic             i_jumpreg,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    input  logic [4:0]       i_shamt,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cond,
    output logic             o_jumpreg,
    output logic             o_illegal
);

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_ADD   = 4'd2,
        OP_SLL   = 4'd3,
        OP_SRL   = 4'd4,
        OP_SUBNE = 4'd5,
        OP_SUBEQ = 4'd6,
        OP_SLT   = 4'd7,
        OP_LUI   = 4'd8,
        OP_NOR   = 4'd12,
        OP_XOR   = 4'd13,
        OP_PASSA = 4'd14
    } alu_op_e;

    logic [WIDTH-1:0] result_d, result_q;
    logic             cond_d, cond_q;
    logic             jr_d, jr_q;
    logic             ill_d, ill_q;
    logic             valid_d, valid_q;

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] b_lo;
    logic             accept;

    assign diff = i_opa - i_opb;

    always_comb begin
        b_lo       = '0;
        b_lo[15:0] = i_opb[15:0];
    end

    // ALU function; unsupported codes yield zero and raise the illegal flag.
    always_comb begin
        result_d = '0;
        cond_d   = 1'b0;
        ill_d    = 1'b0;
        case (i_alu_ctrl)
            OP_AND:   result_d = i_opa & i_opb;
            OP_OR:    result_d = i_opa | i_opb;
            OP_ADD:   result_d = i_opa + i_opb;
            OP_SLL:   result_d = i_opb << i_shamt;
            OP_SRL:   result_d = i_opb >> i_shamt;
            OP_SUBNE: begin
                result_d = diff;
                cond_d   = (i_opa != i_opb);
            end
            OP_SUBEQ: begin
                result_d = diff;
                cond_d   = (i_opa == i_opb);
            end
            OP_SLT:   result_d[0] = ($signed(i_opa) < $signed(i_opb));
            OP_LUI:   result_d = b_lo << (WIDTH - 16);
            OP_NOR:   result_d = ~(i_opa | i_opb);
            OP_XOR:   result_d = i_opa ^ i_opb;
            OP_PASSA: result_d = i_opa;
            default:  ill_d = 1'b1;
        endcase
        jr_d = i_jumpreg | (i_alu_ctrl == OP_PASSA);
    end

    assign o_ready = !valid_q | i_ready;
    assign accept  = i_valid & o_ready & !i_flush;

    always_comb begin
        valid_d = valid_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (valid_q & i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Flags are cleared whenever the slot empties so they read 0 while
    // o_valid=0; the result register is only written on accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            cond_q   <= 1'b0;
            jr_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                result_q <= result_d;
                cond_q   <= cond_d;
                jr_q     <= jr_d;
                ill_q    <= ill_d;
            end else if (!valid_d) begin
                cond_q   <= 1'b0;
                jr_q     <= 1'b0;
                ill_q    <= 1'b0;
            end
        end
    end

    assign o_valid   = valid_q;
    assign o_result  = result_q;
    assign o_cond    = cond_q;
    assign o_jumpreg = jr_q;
    assign o_illegal = ill_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes expected results on accept,
// a negedge monitor pops and compares on every downstream handshake.
module tb_ex_stage;

    typedef struct {
        logic [31:0] res;
        logic        cond;
        logic        jr;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  alu_ctrl;
    logic        jumpreg;
    logic [31:0] opa, opb;
    logic [4:0]  shamt;
    logic        flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_cond, o_jumpreg, o_illegal;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ex_stage #(.WIDTH(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_alu_ctrl (alu_ctrl),
        .i_jumpreg  (jumpreg),
        .i_opa      (opa),
        .i_opb      (opb),
        .i_shamt    (shamt),
        .i_flush    (flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_cond     (o_cond),
        .o_jumpreg  (o_jumpreg),
        .o_illegal  (o_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed at the next edge when valid & ready and no kill.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o_valid && i_ready && !flush) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %h expected none", o_result);
                end else begin
                    e = sb.pop_front();
                    if (o_result !== e.res || o_cond !== e.cond ||
                        o_jumpreg !== e.jr || o_illegal !== e.ill) begin
                        errors++;
                        $display("FAIL sb_result: got res=%h cond=%b jr=%b ill=%b expected res=%h cond=%b jr=%b ill=%b",
                                 o_result, o_cond, o_jumpreg, o_illegal, e.res, e.cond, e.jr, e.ill);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] c, input logic jr,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic fl, input logic rdy, input logic push,
                         input logic [31:0] er, input logic ec, input logic ejr, input logic eill);
        exp_t e;
        i_valid = v; alu_ctrl = c; jumpreg = jr; opa = a; opb = b;
        shamt = sh; flush = fl; i_ready = rdy;
        if (push) begin
            e.res = er; e.cond = ec; e.jr = ejr; e.ill = eill;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic op(input logic [3:0] c, input logic jr, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh,
                      input logic [31:0] er, input logic ec, input logic ejr, input logic eill);
        drive(1'b1, c, jr, a, b, sh, 1'b0, 1'b1, 1'b1, er, ec, ejr, eill);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_valid = 1'b0; alu_ctrl = '0; jumpreg = 1'b0; opa = '0; opb = '0;
        shamt = '0; flush = 1'b0; i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, o_valid}, 32'h0);
        check("rst_result", o_result, 32'h0);
        check("rst_flags", {29'b0, o_cond, o_jumpreg, o_illegal}, 32'h0);
        rst_n = 1'b1;
        check("rst_ready", {31'b0, o_ready}, 32'h1);

        // Add/sub with wrap and equality branch
        op(4'd2, 1'b0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("lat1_valid", {31'b0, o_valid}, 32'h1);
        op(4'd6, 1'b0, 32'h5, 32'h5, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        op(4'd5, 1'b0, 32'h7, 32'h3, 5'd0, 32'h4, 1'b1, 1'b0, 1'b0);
        // Ops sweep
        op(4'd7, 1'b0, 32'h80000000, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1'b0);
        op(4'd8, 1'b0, 32'h0, 32'h1234, 5'd0, 32'h12340000, 1'b0, 1'b0, 1'b0);
        op(4'd3, 1'b0, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0);
        op(4'd4, 1'b0, 32'h0, 32'h80000000, 5'd31, 32'h1, 1'b0, 1'b0, 1'b0);
        op(4'd11, 1'b0, 32'h3, 32'h4, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        op(4'd15, 1'b0, 32'h3, 32'h4, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        op(4'd3, 1'b0, 32'h0, 32'hABCD, 5'd0, 32'hABCD, 1'b0, 1'b0, 1'b0);
        op(4'd2, 1'b1, 32'h1, 32'h2, 5'd0, 32'h3, 1'b0, 1'b1, 1'b0);
        idle();
        check("idle_valid", {31'b0, o_valid}, 32'h0);
        check("idle_flags", {29'b0, o_cond, o_jumpreg, o_illegal}, 32'h0);

        // Streaming: 8 back-to-back ops, o_valid must stay high throughout
        op(4'd0, 1'b0, 32'hF0F0, 32'hFF00, 5'd0, 32'hF000, 1'b0, 1'b0, 1'b0);
        op(4'd1, 1'b0, 32'hF0F0, 32'h0F0F, 5'd0, 32'hFFFF, 1'b0, 1'b0, 1'b0);
        check("stream_valid1", {31'b0, o_valid}, 32'h1);
        op(4'd12, 1'b0, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        op(4'd13, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'hF00FF00F, 1'b0, 1'b0, 1'b0);
        check("stream_valid3", {31'b0, o_valid}, 32'h1);
        op(4'd2, 1'b0, 32'h10, 32'h20, 5'd0, 32'h30, 1'b0, 1'b0, 1'b0);
        op(4'd6, 1'b0, 32'h1, 32'h2, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        op(4'd7, 1'b0, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        op(4'd4, 1'b0, 32'h0, 32'hF0000000, 5'd4, 32'h0F000000, 1'b0, 1'b0, 1'b0);
        check("stream_valid8", {31'b0, o_valid}, 32'h1);
        idle();

        // Backpressure: result held stable while inputs change
        op(4'd2, 1'b0, 32'h100, 32'h23, 5'd0, 32'h123, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 4), 1'b1, 32'h5A5A0000 + 32'(i), 32'h77, 5'd3, 1'b0, 1'b0, 1'b0,
                  32'h0, 1'b0, 1'b0, 1'b0);
            check("bp_ready", {31'b0, o_ready}, 32'h0);
            check("bp_result", o_result, 32'h123);
            check("bp_valid", {31'b0, o_valid}, 32'h1);
        end
        op(4'd13, 1'b0, 32'hAAAA, 32'h5555, 5'd0, 32'hFFFF, 1'b0, 1'b0, 1'b0);
        check("bp_resume_valid", {31'b0, o_valid}, 32'h1);
        idle();

        // jr, then flush with an incoming op
        op(4'd14, 1'b0, 32'h00400020, 32'h9, 5'd0, 32'h00400020, 1'b0, 1'b1, 1'b0);
        check("jr_flag", {31'b0, o_jumpreg}, 32'h1);
        idle();
        drive(1'b1, 4'd2, 1'b0, 32'h1, 32'h1, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("flush_in_valid", {31'b0, o_valid}, 32'h0);
        // Flush a held op under stall
        drive(1'b1, 4'd14, 1'b0, 32'hDEAD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("pre_flush_valid", {31'b0, o_valid}, 32'h1);
        drive(1'b1, 4'd2, 1'b0, 32'h1, 32'h1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("flush_held_valid", {31'b0, o_valid}, 32'h0);
        check("flush_held_flags", {29'b0, o_cond, o_jumpreg, o_illegal}, 32'h0);
        idle();
        check("flush_nocapture", {31'b0, o_valid}, 32'h0);

        // Reset during a stall discards the held op
        drive(1'b1, 4'd6, 1'b0, 32'h9, 32'h9, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_valid", {31'b0, o_valid}, 32'h1);
        rst_n = 1'b0;
        drive(1'b1, 4'd2, 1'b0, 32'h1, 32'h1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("mrst_valid", {31'b0, o_valid}, 32'h0);
        check("mrst_result", o_result, 32'h0);
        check("mrst_flags", {29'b0, o_cond, o_jumpreg, o_illegal}, 32'h0);
        check("mrst_ready", {31'b0, o_ready}, 32'h1);
        op(4'd1, 1'b0, 32'h1, 32'h2, 5'd0, 32'h3, 1'b0, 1'b0, 1'b0);
        idle();

        for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
